// File: rtl/mem_stage_lsu.sv
// rtl/mem_stage_lsu.sv - memory-stage load/store unit with valid/ready dmem port and M->W register
// Sized, lane-aligned loads/stores; misaligned or unsupported accesses skip memory and flag W.
module mem_stage_lsu #(
  parameter int XLEN = 32,
  parameter int RS_W = 3,
  parameter int RD_W = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              valid_m,
  input  logic [XLEN-1:0]   alu_out_m,
  input  logic [XLEN-1:0]   wdata_m,
  input  logic              mem_read_m,
  input  logic              mem_write_m,
  input  logic [2:0]        funct3_m,
  input  logic [XLEN-1:0]   imm_u_m,
  input  logic [XLEN-1:0]   pc_m,
  input  logic [XLEN-1:0]   pcplus4_m,
  input  logic [RS_W-1:0]   result_src_m,
  input  logic              reg_write_m,
  input  logic [RD_W-1:0]   rd_m,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [XLEN-1:0]   dmem_addr,
  output logic [XLEN-1:0]   dmem_wdata,
  output logic [XLEN/8-1:0] dmem_be,
  input  logic [XLEN-1:0]   dmem_rdata,
  input  logic              dmem_ready,
  output logic              stall_m,
  output logic [XLEN-1:0]   fwd_m,
  output logic              reg_write_h,
  output logic [RD_W-1:0]   rd_h,
  output logic              valid_w,
  output logic              reg_write_w,
  output logic              misalign_w,
  output logic [XLEN-1:0]   alu_out_w,
  output logic [XLEN-1:0]   load_data_w,
  output logic [XLEN-1:0]   imm_u_w,
  output logic [XLEN-1:0]   pc_w,
  output logic [XLEN-1:0]   pcplus4_w,
  output logic [RS_W-1:0]   result_src_w,
  output logic [RD_W-1:0]   rd_w
);

  localparam int NB    = XLEN / 8;
  localparam int OFF_W = $clog2(NB);
  localparam bit IS64  = (XLEN == 64);

  typedef enum logic {S_IDLE, S_WAIT} state_t;

  state_t            state, stateNext;
  logic              access, aligned, misalign, isLoad, signBit;
  logic [1:0]        size;
  logic [OFF_W-1:0]  offset;
  logic [NB-1:0]     sizeMask;
  logic [XLEN-1:0]   shifted, widthMask, loadData;

  assign access   = valid_m & (mem_read_m | mem_write_m);
  assign isLoad   = mem_read_m & ~mem_write_m;
  assign size     = funct3_m[1:0];
  assign offset   = alu_out_m[OFF_W-1:0];
  assign misalign = access & ~aligned;

  assign fwd_m       = alu_out_m;
  assign reg_write_h = reg_write_m & valid_m;
  assign rd_h        = rd_m;

  always_comb begin
    case (size)
      2'b00:   aligned = 1'b1;
      2'b01:   aligned = ~alu_out_m[0];
      2'b10:   aligned = (alu_out_m[1:0] == 2'b00);
      default: aligned = (alu_out_m[2:0] == 3'b000);
    endcase
    // Encodings with no legal access at this width are reported as misaligned.
    if (funct3_m == 3'b111 || (!IS64 && (funct3_m == 3'b011 || funct3_m == 3'b110)))
      aligned = 1'b0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= stateNext;
  end

  always_comb begin
    stateNext = state;
    dmem_req  = 1'b0;
    case (state)
      S_IDLE: begin
        dmem_req = access & aligned;
        if (dmem_req && !dmem_ready) stateNext = S_WAIT;
      end
      S_WAIT: begin
        dmem_req = 1'b1;
        if (dmem_ready) stateNext = S_IDLE;
      end
      default: stateNext = S_IDLE;
    endcase
    // Dropping req during reset is the abort signal to memory.
    if (reset) dmem_req = 1'b0;
  end

  assign stall_m   = dmem_req & ~dmem_ready;
  assign dmem_we   = mem_write_m;
  assign dmem_addr = {alu_out_m[XLEN-1:OFF_W], {OFF_W{1'b0}}};
  assign dmem_be   = sizeMask << offset;

  always_comb begin
    case (size)
      2'b00: begin
        sizeMask   = NB'(8'h01);
        dmem_wdata = {NB{wdata_m[7:0]}};
      end
      2'b01: begin
        sizeMask   = NB'(8'h03);
        dmem_wdata = {(NB/2){wdata_m[15:0]}};
      end
      2'b10: begin
        sizeMask   = NB'(8'h0F);
        dmem_wdata = {(XLEN/32){wdata_m[31:0]}};
      end
      default: begin
        sizeMask   = '1;
        dmem_wdata = wdata_m;
      end
    endcase
  end

  always_comb begin
    shifted = dmem_rdata >> {offset, 3'b000};
    case (size)
      2'b00: begin
        widthMask = XLEN'(64'hFF);
        signBit   = shifted[7];
      end
      2'b01: begin
        widthMask = XLEN'(64'hFFFF);
        signBit   = shifted[15];
      end
      2'b10: begin
        widthMask = XLEN'(64'hFFFF_FFFF);
        signBit   = shifted[31];
      end
      default: begin
        widthMask = '1;
        signBit   = 1'b0;
      end
    endcase
    loadData = (shifted & widthMask) | ((~funct3_m[2] & signBit) ? ~widthMask : '0);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_w      <= 1'b0;
      reg_write_w  <= 1'b0;
      misalign_w   <= 1'b0;
      alu_out_w    <= '0;
      load_data_w  <= '0;
      imm_u_w      <= '0;
      pc_w         <= '0;
      pcplus4_w    <= '0;
      result_src_w <= '0;
      rd_w         <= '0;
    end else if (stall_m) begin
      valid_w     <= 1'b0;
      reg_write_w <= 1'b0;
      misalign_w  <= 1'b0;
    end else begin
      valid_w      <= valid_m;
      reg_write_w  <= valid_m & reg_write_m & ~misalign;
      misalign_w   <= misalign;
      alu_out_w    <= alu_out_m;
      load_data_w  <= (valid_m & isLoad & aligned) ? loadData : '0;
      imm_u_w      <= imm_u_m;
      pc_w         <= pc_m;
      pcplus4_w    <= pcplus4_m;
      result_src_w <= result_src_m;
      rd_w         <= rd_m;
    end
  end

endmodule
